uart_sector_packer: RTL and testbench

Byte-to-sector staging buffer between the UART receiver and the SD-card SPI write controller. Pairs received UART bytes into 16-bit words and buffers them in a two-sector FIFO. Once a full 512-byte sector is buffered, it requests one SD write and streams the sector out on the writer's `wr_en` strobe. It also owns the sector address counter, which advances synchronously after each completed write; no logic is clocked from `wr_en`.

---
 rtl/uart_sector_packer_pkg.sv | 6 +
 rtl/uart_sector_packer_sync_fifo_fwft.sv | 36 +++
 rtl/uart_sector_packer.sv | 75 +++++++
 tb/tb_uart_sector_packer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_sector_packer_pkg.sv
// uart_sector_packer_pkg: shared constants and types for the UART-to-SD sector path
package uart_sector_packer_pkg;
  localparam int SD_SECTOR_BYTES = 512;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  typedef logic [31:0] sector_addr_t;
endpackage

// File: rtl/uart_sector_packer_sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign full  = count == FULL_CNT;
  assign empty = count == '0;
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  // pointer update; blocked push/pop leave pointers untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage write, no reset needed since reads are gated by empty
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_sector_packer.sv
// uart_sector_packer: pairs UART bytes into words and hands full sectors to the SD writer
module uart_sector_packer
  import uart_sector_packer_pkg::*;
#(
  parameter sector_addr_t START_ADDR   = 32'h0,
  parameter int           SECTOR_WORDS = SD_SECTOR_BYTES / 2,
  parameter int           FIFO_WORDS   = 512
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         rx_flag,
  input  logic [7:0]   rx_data,
  output logic         wr_req,
  output sector_addr_t wr_addr,
  input  logic         wr_en,
  output logic [15:0]  wr_data,
  input  logic         wr_busy,
  output logic         overflow,
  output logic         len_err
);
  localparam int CW = $clog2(FIFO_WORDS) + 1;
  localparam logic [CW-1:0] SECTOR_CNT = CW'(SECTOR_WORDS);
  localparam logic [8:0] SECTOR_POPS = 9'(SECTOR_WORDS);
  state_t state, next;
  logic have_hi, push, pop, full, empty, busy_q;
  logic [7:0] hi;
  logic [CW-1:0] count;
  logic [8:0] pop_cnt;
  assign push   = rx_flag && have_hi;
  assign pop    = (state == XFER) && wr_en;
  assign wr_req = state == REQ;
  sync_fifo_fwft #(.WIDTH(16), .DEPTH(FIFO_WORDS)) u_fifo (
    .clk(sys_clk), .rst_n(sys_rst_n), .push(push), .din({hi, rx_data}),
    .pop(pop), .dout(wr_data), .count(count), .full(full), .empty(empty)
  );
  // next-state logic for the write handshake
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (count >= SECTOR_CNT && !wr_busy) next = REQ;
      REQ:     if (wr_busy) next = XFER;
      XFER:    if (busy_q && !wr_busy) next = DONE;
      default: next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= next;
  // byte-pair latch: first byte of a pair is held as the high byte
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      have_hi <= 1'b0;
      hi      <= '0;
    end else if (rx_flag) begin
      have_hi <= !have_hi;
      if (!have_hi) hi <= rx_data;
    end
  // busy edge detect, pop counting, sector address and sticky flags
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      busy_q   <= 1'b0;
      pop_cnt  <= '0;
      wr_addr  <= START_ADDR;
      overflow <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      busy_q <= wr_busy;
      if (state == REQ) pop_cnt <= '0;
      else if (pop) pop_cnt <= pop_cnt + 1'b1;
      if (state == DONE) wr_addr <= wr_addr + 1'b1;
      if (push && full) overflow <= 1'b1;
      if ((pop && empty) || (state == DONE && pop_cnt != SECTOR_POPS)) len_err <= 1'b1;
    end
endmodule

// File: tb/tb_uart_sector_packer.sv
// tb_uart_sector_packer: directed checks of packing, sector handshake, flags and reset
module tb_uart_sector_packer;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b0, rx_flag = 1'b0, wr_en = 1'b0, wr_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        wr_req, overflow, len_err;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;
  int vectors = 0, errors = 0;

  always #10 sys_clk = ~sys_clk;

  uart_sector_packer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_flag(rx_flag), .rx_data(rx_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
    .wr_busy(wr_busy), .overflow(overflow), .len_err(len_err)
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input int k);
    logic [7:0] a, b;
    a = 8'(2 * k);
    b = 8'(2 * k + 1);
    return {a, b};
  endfunction

  task automatic do_reset;
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    tick;
  endtask

  task automatic send_bytes(input int start, input int n);
    for (int j = start; j < start + n; j++) begin
      rx_flag = 1'b1;
      rx_data = 8'(j);
      tick;
    end
    rx_flag = 1'b0;
  endtask

  task automatic wait_req;
    int n = 0;
    while (wr_req !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    chk("wr_req_seen", 32'(wr_req), 32'd1);
  endtask

  task automatic service(input int pops, input int first_word, input logic [31:0] addr);
    wait_req;
    chk("addr_at_req", wr_addr, addr);
    wr_busy = 1'b1;
    tick;
    chk("req_drop", 32'(wr_req), 32'd0);
    for (int k = 0; k < pops; k++) begin
      chk("wr_data", 32'(wr_data), 32'(word(first_word + k)));
      wr_en = 1'b1;
      tick;
    end
    wr_en = 1'b0;
    wr_busy = 1'b0;
    tick;
    chk("addr_hold", wr_addr, addr);
    tick;
    chk("addr_inc", wr_addr, addr + 32'd1);
  endtask

  initial begin
    tick;
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    sys_rst_n = 1'b1;
    tick;
    // single sector: request timing, data order, address advance
    send_bytes(0, 512);
    chk("t1_req_early", 32'(wr_req), 32'd0);
    tick;
    chk("t1_req_rise", 32'(wr_req), 32'd1);
    service(256, 0, 32'd0);
    chk("t1_len_err", 32'(len_err), 32'd0);
    // two back-to-back sectors
    do_reset;
    send_bytes(0, 1024);
    chk("t2_req", 32'(wr_req), 32'd1);
    service(256, 0, 32'd0);
    chk("t2_gap", 32'(wr_req), 32'd0);
    tick;
    chk("t2_req2", 32'(wr_req), 32'd1);
    service(256, 256, 32'd1);
    chk("t2_len_err", 32'(len_err), 32'd0);
    tick;
    chk("t2_empty_req", 32'(wr_req), 32'd0);
    chk("t2_empty_data", 32'(wr_data), 32'h0);
    // reset in the middle of a transfer at address 2
    send_bytes(0, 512);
    wait_req;
    chk("t6_addr", wr_addr, 32'd2);
    wr_busy = 1'b1;
    tick;
    for (int k = 0; k < 100; k++) begin
      chk("t6_data", 32'(wr_data), 32'(word(k)));
      wr_en = 1'b1;
      tick;
    end
    wr_en = 1'b0;
    wr_busy = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_wr_req", 32'(wr_req), 32'd0);
    chk("t6_wr_addr", wr_addr, 32'h0);
    chk("t6_wr_data", 32'(wr_data), 32'h0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_len_err", 32'(len_err), 32'd0);
    tick;
    sys_rst_n = 1'b1;
    repeat (3) tick;
    chk("t6_post_req", 32'(wr_req), 32'd0);
    chk("t6_post_data", 32'(wr_data), 32'h0);
    // short write: 255 pops
    send_bytes(0, 512);
    service(255, 0, 32'd0);
    chk("t5_len_err", 32'(len_err), 32'd1);
    chk("t5_overflow", 32'(overflow), 32'd0);
    // 511 bytes leave one word short and a byte in the latch
    do_reset;
    chk("t3_len_clr", 32'(len_err), 32'd0);
    send_bytes(0, 511);
    repeat (10) tick;
    chk("t3_no_req", 32'(wr_req), 32'd0);
    send_bytes(511, 1);
    chk("t3_req_early", 32'(wr_req), 32'd0);
    tick;
    chk("t3_req", 32'(wr_req), 32'd1);
    // overflow with writer idle
    do_reset;
    send_bytes(0, 1024);
    chk("t4_no_ovf", 32'(overflow), 32'd0);
    send_bytes(1024, 2);
    chk("t4_ovf", 32'(overflow), 32'd1);
    service(256, 0, 32'd0);
    service(256, 256, 32'd1);
    chk("t4_empty_data", 32'(wr_data), 32'h0);
    repeat (5) tick;
    chk("t4_no_req", 32'(wr_req), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    chk("t4_len_err", 32'(len_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
